// File: rtl/pipelined_seg_adder.sv
// Segmented, pipelined add/subtract unit: one SEG_W-bit slice per stage, carry registered between stages.
// Optional PIPE_ADDER_SAT_EN: clamp the result to the signed limit on two's-complement overflow.
module pipelined_seg_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG_W;
    localparam int MSB  = WIDTH - 1;

    generate
        if (SEG_W < 1 || WIDTH < SEG_W || (WIDTH % SEG_W) != 0) begin : g_param_check
            $error("pipelined_seg_adder: WIDTH must be a non-zero multiple of SEG_W");
        end
    endgenerate

    // Handshake: a beat moves on valid && ready. The whole pipe advances together whenever the
    // output register is empty or being drained; in_ready never looks at in_valid.
    logic             adv;

    logic [NSEG-1:0]  vld_q, vld_d;
    logic [NSEG-1:0]  cy_q, cy_d;
    logic [WIDTH-1:0] opa_q  [NSEG];
    logic [WIDTH-1:0] opa_d  [NSEG];
    logic [WIDTH-1:0] opb_q  [NSEG];
    logic [WIDTH-1:0] opb_d  [NSEG];
    logic [WIDTH-1:0] psum_q [NSEG];
    logic [WIDTH-1:0] psum_d [NSEG];
    logic             ovf_q, ovf_d;

    always_comb begin
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic [WIDTH-1:0] nxt_s;
        logic             src_c;
        logic             src_v;
        logic [SEG_W-1:0] seg_s;
        logic             seg_c;
        int               prev;

        adv   = !vld_q[NSEG-1] || out_ready;
        vld_d = vld_q;
        cy_d  = cy_q;
        ovf_d = ovf_q;
        src_a = '0;
        src_b = '0;
        src_s = '0;
        nxt_s = '0;
        src_c = 1'b0;
        src_v = 1'b0;
        seg_s = '0;
        seg_c = 1'b0;
        prev  = 0;
        for (int k = 0; k < NSEG; k++) begin
            opa_d[k]  = opa_q[k];
            opb_d[k]  = opb_q[k];
            psum_d[k] = psum_q[k];
        end

        for (int k = 0; k < NSEG; k++) begin
            prev = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
                src_a = a;
                src_b = sub ? ~b : b;
                src_s = '0;
                src_c = sub | cin;
                src_v = in_valid;
            end else begin
                src_a = opa_q[prev];
                src_b = opb_q[prev];
                src_s = psum_q[prev];
                src_c = cy_q[prev];
                src_v = vld_q[prev];
            end

            {seg_c, seg_s} = {1'b0, src_a[k*SEG_W +: SEG_W]}
                           + {1'b0, src_b[k*SEG_W +: SEG_W]}
                           + {{SEG_W{1'b0}}, src_c};
            nxt_s = src_s;
            nxt_s[k*SEG_W +: SEG_W] = seg_s;

            if (k == NSEG - 1) begin
                ovf_d = (src_a[MSB] == src_b[MSB]) && (nxt_s[MSB] != src_a[MSB]);
`ifdef PIPE_ADDER_SAT_EN
                // Overflow direction follows the shared operand sign.
                if (ovf_d) begin
                    nxt_s = src_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            opa_d[k]  = src_a;
            opb_d[k]  = src_b;
            psum_d[k] = nxt_s;
            cy_d[k]   = seg_c;
            vld_d[k]  = src_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                opa_q[k]  <= '0;
                opb_q[k]  <= '0;
                psum_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < NSEG; k++) begin
                opa_q[k]  <= opa_d[k];
                opb_q[k]  <= opb_d[k];
                psum_q[k] <= psum_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[NSEG-1];
    assign sum       = psum_q[NSEG-1];
    assign cout      = cy_q[NSEG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_seg_adder.sv
// Scoreboard bench for pipelined_seg_adder at WIDTH=16, SEG_W=8 (latency 2).
module tb_pipelined_seg_adder;

  localparam int W = 16;
`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];

  pipelined_seg_adder #(.WIDTH(W), .SEG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver: called at posedge+1; returns at posedge+1 after the beat transferred
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                      input logic tsub, input logic [W-1:0] esum, input logic ecout,
                      input logic eovf);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    cin = tcin;
    sub = tsub;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 100) break;
    end
    if (guard > 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end else begin
      exp_q.push_back({esum, ecout, eovf});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // checks the 2-cycle latency of a beat just accepted into an empty pipe
  task automatic check_latency(input string tag);
    @(negedge clk);
    chk({tag, "_early"}, {15'b0, out_valid}, 16'd0);
    @(negedge clk);
    chk({tag, "_on_time"}, {15'b0, out_valid}, 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=sum_%h required=no_beat", sum);
      end else begin
        e = exp_q[0];
        chk("sum", sum, e[W+1:2]);
        chk("cout", {15'b0, cout}, {15'b0, e[1]});
        chk("ovf", {15'b0, ovf}, {15'b0, e[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  logic [W-1:0] s5 [8];

  initial begin
    logic [W-1:0] ti;
    s5 = '{16'h0000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", {15'b0, cout}, 16'd0);
    chk("rst_ovf", {15'b0, ovf}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // cross-segment carry with latency check
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    check_latency("t1_lat");
    drain();

    // directed vectors
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1);
    send(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    send(16'h00FF, 16'h00FF, 1'b1, 1'b0, 16'h01FF, 1'b0, 1'b0);
    send(16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0);
    drain();

    // back-to-back stream with a 3-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ti = W'(i);
          send(ti, ti << 8, 1'b0, 1'b0, s5[i], 1'b0, 1'b0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_out_valid", {15'b0, out_valid}, 16'd1);
          chk("stall_in_ready", {15'b0, in_ready}, 16'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // asynchronous reset with two beats in flight
    send(16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0);
    send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", {15'b0, out_valid}, 16'd0);
    chk("arst_sum", sum, 16'h0000);
    chk("arst_cout", {15'b0, cout}, 16'd0);
    chk("arst_ovf", {15'b0, ovf}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {15'b0, out_valid}, 16'd0);
    end
    @(posedge clk);
    #1;
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    check_latency("t6_lat");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
